// File: rtl/guess_evaluator.sv
// Wordle row evaluator: holds the row being edited, scores it against the target
// with duplicate-aware green/yellow passes, and tracks row count, win and lose.
module guess_evaluator #(
   parameter int NUM_ROWS = 6,
   parameter int BLANK    = 26
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        wr_en,
   input  logic [2:0]  wr_col,
   input  logic [6:0]  wr_value,
   input  logic        submit,
   input  logic [24:0] target_word,
   output logic [34:0] row_values,
   output logic        busy,
   output logic        result_valid,
   output logic [34:0] result_row,
   output logic        result_invalid,
   output logic [2:0]  row_index,
   output logic        win,
   output logic        lose,
   output logic        game_over
);

   typedef enum logic [2:0] {IDLE, CHECK, GREEN, YELLOW, REPORT} state_t;

   localparam logic [2:0] MAXR  = 3'(NUM_ROWS);
   localparam logic [4:0] BLNK  = 5'(BLANK);
   localparam logic [1:0] GREY  = 2'd0;
   localparam logic [1:0] YELW  = 2'd1;
   localparam logic [1:0] GRN   = 2'd2;
   localparam logic [1:0] RED   = 2'd3;

   state_t state, state_nxt;

   logic [4:0][4:0] slot, slot_w, guess, tgt;
   logic [4:0][1:0] color, color_nxt;
   logic [4:0]      used, used_nxt, bad;
   logic [2:0]      idx, fj;
   logic            found, any_bad, all_green, invalid_q, take_submit;
   logic [4:0][6:0] res_q;

   assign tgt         = target_word;
   assign busy        = (state != IDLE);
   assign result_valid = (state == REPORT);
   assign result_invalid = (state == REPORT) && invalid_q;
   assign game_over   = win | lose;
   assign result_row  = res_q;
   assign take_submit = (state == IDLE) && submit && !game_over;
   assign all_green   = (color == {5{GRN}});

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         row_values[7*i +: 7] = {2'b00, slot[i]};
         bad[i] = (guess[i] >= BLNK);
      end
   end
   assign any_bad = |bad;

   // Write is merged before the snapshot so a same-cycle submit sees it.
   always_comb begin
      slot_w = slot;
      if (state == IDLE && !game_over && wr_en && wr_col < 3'd5)
         slot_w[wr_col] = wr_value[4:0];
   end

   // Lowest unused target position holding the current guess letter.
   always_comb begin
      found = 1'b0;
      fj    = 3'd0;
      for (int j = 4; j >= 0; j--) begin
         if (!used[j] && tgt[j] == guess[idx]) begin
            found = 1'b1;
            fj    = 3'(j);
         end
      end
   end

   always_comb begin
      color_nxt = color;
      used_nxt  = used;
      if (state == GREEN && guess[idx] == tgt[idx]) begin
         color_nxt[idx] = GRN;
         used_nxt[idx]  = 1'b1;
      end else if (state == YELLOW && color[idx] != GRN && found) begin
         color_nxt[idx] = YELW;
         used_nxt[fj]   = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take_submit) state_nxt = CHECK;
         CHECK:   state_nxt = any_bad ? REPORT : GREEN;
         GREEN:   if (idx == 3'd4) state_nxt = YELLOW;
         YELLOW:  if (idx == 3'd4) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         slot      <= '0;
         guess     <= '0;
         color     <= '0;
         used      <= '0;
         idx       <= '0;
         invalid_q <= 1'b0;
         res_q     <= '0;
         row_index <= '0;
         win       <= 1'b0;
         lose      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               slot <= slot_w;
               if (take_submit) guess <= slot_w;
            end
            CHECK: begin
               if (any_bad) begin
                  invalid_q <= 1'b1;
                  for (int i = 0; i < 5; i++)
                     res_q[i] <= {bad[i] ? RED : GREY, guess[i]};
               end else begin
                  invalid_q <= 1'b0;
                  used      <= '0;
                  color     <= '0;
                  idx       <= '0;
               end
            end
            GREEN: begin
               color <= color_nxt;
               used  <= used_nxt;
               idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end
            YELLOW: begin
               color <= color_nxt;
               used  <= used_nxt;
               idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
               if (idx == 3'd4)
                  for (int i = 0; i < 5; i++)
                     res_q[i] <= {color_nxt[i], guess[i]};
            end
            REPORT: begin
               if (!invalid_q) begin
                  slot <= '0;
                  if (row_index != MAXR) row_index <= row_index + 3'd1;
                  if (all_green) win <= 1'b1;
                  else if (row_index + 3'd1 == MAXR) lose <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed bench for guess_evaluator: scoring, invalid rows, win/lose, write races, abort.
module tb_guess_evaluator;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_col = '0;
   logic [6:0]  wr_value = '0;
   logic        submit = 1'b0;
   logic [24:0] target_word = '0;
   logic [34:0] row_values, result_row;
   logic        busy, result_valid, result_invalid, win, lose, game_over;
   logic [2:0]  row_index;

   int checks = 0;
   int errors = 0;

   guess_evaluator #(.NUM_ROWS(6), .BLANK(26)) dut (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_col(wr_col), .wr_value(wr_value),
      .submit(submit), .target_word(target_word), .row_values(row_values),
      .busy(busy), .result_valid(result_valid), .result_row(result_row),
      .result_invalid(result_invalid), .row_index(row_index), .win(win),
      .lose(lose), .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic logic [24:0] w5(input int a, b, c, d, e);
      return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   function automatic logic [34:0] mkrow(input logic [24:0] l, input int c0, c1, c2, c3, c4);
      logic [4:0][4:0] lt;
      logic [4:0][1:0] ct;
      logic [34:0] r;
      lt = l;
      ct = {2'(c4), 2'(c3), 2'(c2), 2'(c1), 2'(c0)};
      for (int i = 0; i < 5; i++) r[7*i +: 7] = {ct[i], lt[i]};
      return r;
   endfunction

   // All tasks start and end just after a negedge.
   task automatic do_reset();
      clr = 1'b1;
      #1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic wr(input int col, input int letter);
      wr_en = 1'b1; wr_col = 3'(col); wr_value = 7'(letter);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic write_row(input logic [24:0] l);
      for (int i = 0; i < 5; i++) wr(i, int'(l[5*i +: 5]));
   endtask

   // lat = edges after the submit edge up to the one that samples result_valid high.
   task automatic submit_wait(output int lat);
      submit = 1'b1;
      @(posedge clk);
      #1 submit = 1'b0;
      lat = 99;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (result_valid) begin lat = n; break; end
      end
   endtask

   task automatic no_response(input string name);
      logic seen;
      seen = 1'b0;
      submit = 1'b1;
      @(posedge clk);
      #1 submit = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (result_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL %s: busy/result_valid got 1 required 0", name);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({row_values, result_row, busy, result_valid, result_invalid, row_index, win, lose, game_over} !== '0) begin
         errors++; $display("FAIL reset: outputs not all zero rv=%h rr=%h ri=%0d", row_values, result_row, row_index);
      end
      wr(5, 9);
      wr(7, 9);
      checks++;
      if (row_values !== 35'd0) begin
         errors++; $display("FAIL wr_col_oob: row_values got %h required 0", row_values);
      end
   endtask

   task automatic test_win();
      int lat;
      do_reset();
      target_word = w5(2, 17, 0, 13, 4);
      write_row(w5(2, 17, 0, 13, 4));
      submit_wait(lat);
      checks++;
      if (lat != 12) begin errors++; $display("FAIL win_latency: got %0d required 12", lat); end
      checks++;
      if (result_row !== mkrow(w5(2, 17, 0, 13, 4), 2, 2, 2, 2, 2) || result_invalid !== 1'b0) begin
         errors++; $display("FAIL win_row: got %h inv %b required %h inv 0", result_row, result_invalid,
                            mkrow(w5(2, 17, 0, 13, 4), 2, 2, 2, 2, 2));
      end
      @(negedge clk);
      checks++;
      if ({win, lose, game_over, row_index, row_values} !== {1'b1, 1'b0, 1'b1, 3'd1, 35'd0}) begin
         errors++; $display("FAIL win_flags: win %b lose %b go %b ri %0d rv %h required 1 0 1 1 0",
                            win, lose, game_over, row_index, row_values);
      end
      no_response("win_resubmit");
   endtask

   task automatic test_duplicates();
      int lat;
      do_reset();
      target_word = w5(0, 15, 15, 11, 4);
      write_row(w5(15, 0, 15, 15, 24));
      submit_wait(lat);
      checks++;
      if (lat != 12 || result_row !== mkrow(w5(15, 0, 15, 15, 24), 1, 1, 2, 0, 0)) begin
         errors++; $display("FAIL dup_row: lat %0d row %h required 12 %h", lat, result_row,
                            mkrow(w5(15, 0, 15, 15, 24), 1, 1, 2, 0, 0));
      end
      @(negedge clk);
      checks++;
      if ({row_index, win, lose, row_values} !== {3'd1, 1'b0, 1'b0, 35'd0}) begin
         errors++; $display("FAIL dup_flags: ri %0d win %b lose %b rv %h required 1 0 0 0",
                            row_index, win, lose, row_values);
      end
   endtask

   task automatic test_invalid();
      int lat;
      logic [34:0] rv_before;
      do_reset();
      target_word = w5(2, 17, 0, 13, 4);
      write_row(w5(2, 17, 0, 26, 4));
      rv_before = row_values;
      submit_wait(lat);
      checks++;
      if (lat != 2 || result_invalid !== 1'b1) begin
         errors++; $display("FAIL inv_latency: lat %0d inv %b required 2 1", lat, result_invalid);
      end
      checks++;
      if (result_row !== mkrow(w5(2, 17, 0, 26, 4), 0, 0, 0, 3, 0)) begin
         errors++; $display("FAIL inv_row: got %h required %h", result_row, mkrow(w5(2, 17, 0, 26, 4), 0, 0, 0, 3, 0));
      end
      @(negedge clk);
      checks++;
      if (row_index !== 3'd0 || row_values !== rv_before || rv_before !== mkrow(w5(2, 17, 0, 26, 4), 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL inv_state: ri %0d rv %h required 0 %h", row_index, row_values,
                            mkrow(w5(2, 17, 0, 26, 4), 0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_lose();
      int lat;
      do_reset();
      target_word = w5(2, 17, 0, 13, 4);
      for (int r = 0; r < 6; r++) begin
         write_row(w5(25, 25, 25, 25, 25));
         submit_wait(lat);
         checks++;
         if (lat != 12 || result_row !== mkrow(w5(25, 25, 25, 25, 25), 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL lose_row%0d: lat %0d row %h required 12 all grey", r, lat, result_row);
         end
         @(negedge clk);
      end
      checks++;
      if ({row_index, lose, win, game_over} !== {3'd6, 1'b1, 1'b0, 1'b1}) begin
         errors++; $display("FAIL lose_flags: ri %0d lose %b win %b go %b required 6 1 0 1",
                            row_index, lose, win, game_over);
      end
      wr(0, 5);
      checks++;
      if (row_values !== 35'd0) begin
         errors++; $display("FAIL lose_write: rv %h required 0", row_values);
      end
      no_response("lose_resubmit");
      checks++;
      if (row_index !== 3'd6) begin errors++; $display("FAIL lose_sat: ri %0d required 6", row_index); end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [34:0] rv_busy;
      do_reset();
      target_word = w5(2, 17, 0, 13, 4);
      wr(0, 2); wr(1, 17); wr(2, 0); wr(3, 13);
      wr_en = 1'b1; wr_col = 3'd4; wr_value = 7'd7; submit = 1'b1;
      @(posedge clk);
      #1 wr_en = 1'b0; submit = 1'b0;
      @(negedge clk);
      wr(0, 10);
      rv_busy = row_values;
      checks++;
      if (busy !== 1'b1 || rv_busy !== mkrow(w5(2, 17, 0, 13, 7), 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL busy_write: busy %b rv %h required 1 %h", busy, rv_busy,
                            mkrow(w5(2, 17, 0, 13, 7), 0, 0, 0, 0, 0));
      end
      lat = 99;
      for (int n = 0; n < 30; n++) begin
         if (result_valid) begin lat = 0; break; end
         @(negedge clk);
      end
      checks++;
      if (lat != 0 || result_row !== mkrow(w5(2, 17, 0, 13, 7), 2, 2, 2, 2, 0)) begin
         errors++; $display("FAIL same_cycle_row: row %h required %h", result_row,
                            mkrow(w5(2, 17, 0, 13, 7), 2, 2, 2, 2, 0));
      end
      @(negedge clk);
      checks++;
      if (win !== 1'b0 || row_index !== 3'd1) begin
         errors++; $display("FAIL same_cycle_flags: win %b ri %0d required 0 1", win, row_index);
      end
   endtask

   task automatic test_abort();
      int lat;
      logic seen;
      do_reset();
      target_word = w5(2, 17, 0, 13, 4);
      write_row(w5(2, 17, 0, 13, 4));
      submit = 1'b1;
      @(posedge clk);
      #1 submit = 1'b0;
      repeat (5) @(posedge clk);
      #2 clr = 1'b1;
      #1;
      checks++;
      if ({row_values, result_row, busy, result_valid, result_invalid, row_index, win, lose} !== '0) begin
         errors++; $display("FAIL abort_reset: busy %b rv %h ri %0d required all 0", busy, row_values, row_index);
      end
      @(negedge clk);
      clr = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_pulse: result_valid got 1 required 0"); end
      write_row(w5(4, 13, 0, 17, 2));
      submit_wait(lat);
      checks++;
      if (lat != 12 || result_row !== mkrow(w5(4, 13, 0, 17, 2), 1, 1, 2, 1, 1)) begin
         errors++; $display("FAIL abort_resume: lat %0d row %h required 12 %h", lat, result_row,
                            mkrow(w5(4, 13, 0, 17, 2), 1, 1, 2, 1, 1));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_win();
      test_duplicates();
      test_invalid();
      test_lose();
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
